// File: rtl/pc_fetch_unit.sv
// Program-counter register and instruction-fetch sequencer.
// Fetches one instruction at a time from instruction memory (req/ready),
// holds it for decode (valid/ack) and advances the PC when it retires.
module pc_fetch_unit #(
    parameter int unsigned             ADDR_W   = 19,
    parameter int unsigned             INSTR_W  = 21,
    parameter logic [ADDR_W-1:0]       RESET_PC = '0
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    // instruction memory
    output logic               o_imem_req,
    output logic [ADDR_W-1:0]  o_imem_addr,
    input  logic [INSTR_W-1:0] i_imem_rdata,
    input  logic               i_imem_ready,
    // decode side
    output logic [INSTR_W-1:0] o_instr,
    output logic               o_instr_valid,
    input  logic               i_instr_ack,
    // next-PC interface
    output logic [ADDR_W-1:0]  o_pc,
    output logic [ADDR_W-1:0]  o_inc_pc,
    input  logic               i_pc_src,
    input  logic [ADDR_W-1:0]  i_target_addr,
    // halt control
    input  logic               i_halt,
    output logic               o_halted
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHold,
        StHalted
    } state_e;

    state_e               r_state;
    state_e               w_state_next;
    logic [ADDR_W-1:0]    r_pc;
    logic [ADDR_W-1:0]    w_pc_next;
    logic [INSTR_W-1:0]   r_instr;
    logic [INSTR_W-1:0]   w_instr_next;
    logic [ADDR_W-1:0]    w_inc_pc;

    // PC+1 wraps naturally at the ADDR_W boundary
    assign w_inc_pc = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   w_state_next = i_halt ? StHalted : StFetch;
            // halt is deliberately not sampled while a fetch is outstanding
            StFetch:  if (i_imem_ready) w_state_next = StHold;
            StHold: begin
                if (i_instr_ack) begin
                    w_state_next = i_halt ? StHalted : StFetch;
                end
            end
            StHalted: w_state_next = StHalted;
            default:  w_state_next = StIdle;
        endcase
    end

    // PC and instruction datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc    <= RESET_PC;
            r_instr <= '0;
        end else begin
            r_pc    <= w_pc_next;
            r_instr <= w_instr_next;
        end
    end

    // Capture the fetched word in FETCH, advance the PC on retire in HOLD
    always_comb begin
        w_pc_next    = r_pc;
        w_instr_next = r_instr;
        if (r_state == StFetch && i_imem_ready) begin
            w_instr_next = i_imem_rdata;
        end
        if (r_state == StHold && i_instr_ack) begin
            w_pc_next = i_pc_src ? i_target_addr : w_inc_pc;
        end
    end

    // Moore outputs decoded from state
    always_comb begin
        o_imem_req    = 1'b0;
        o_instr_valid = 1'b0;
        o_halted      = 1'b0;
        unique case (r_state)
            StIdle:   ;
            StFetch:  o_imem_req    = 1'b1;
            StHold:   o_instr_valid = 1'b1;
            StHalted: o_halted      = 1'b1;
            default:  ;
        endcase
    end

    assign o_imem_addr = r_pc;
    assign o_pc        = r_pc;
    assign o_inc_pc    = w_inc_pc;
    assign o_instr     = r_instr;

endmodule
